mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Control unit for the multicycle MIPS core. Sequences the shared alu, regfile, PC/IR flops and unified memory across multiple cycles per instruction.
- Decodes opcode/funct from the IR and issues all datapath enables and mux selects.
- Stalls on a memory ready handshake.
- Sits beside the datapath in the core top level.

Parameters:
None.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- op  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  alu zero flag
- mem_ready  input  1  memory access completes this cycle
- pcen  output  1  PC flop enable = pcwrite | (branch & zero)
- memwrite  output  1  memory write request (level, held until mem_ready)
- irwrite  output  1  IR load enable
- regwrite  output  1  regfile we3
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  regfile wd3 select: 0 = ALUOut, 1 = Data
- regdst  output  1  wa3 select: 0 = rt, 1 = rd
- alusrca  output  1  0 = PC, 1 = A
- alusrcb  output  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  alu alucont
- illegal_op  output  1  one-cycle pulse on unsupported op/funct
- state_o  output  4  current state (debug)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset behaviour: on a rising edge with reset=1, state := FETCH (0). While reset=1, all outputs except state_o are forced to 0.
- Output style: Moore decode from state. Exceptions: pcen uses the zero input, and the FETCH/MEMRD/MEMWR qualifiers use mem_ready.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 are unreachable and go to FETCH with illegal_op=1.
- Unlisted outputs in each state are 0.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00.
  - Next state by op: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX.
  - Any other op, or op=000000 with a funct outside {100000, 100010, 100100, 100101, 101010}: illegal_op=1 for this cycle, then FETCH (instruction treated as a nop; PC already advanced).
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Stays until mem_ready=1, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1. Stays until mem_ready=1, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1 → FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
- ADDIWB: regwrite=1 → FETCH.
- JEX: pcsrc=10, pcwrite=1 → FETCH.
- aludec (combinational):
  - aluop 00 → 010 (add); 01 → 110 (sub); 11 → 010.
  - aluop 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, other → 010.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset asserted mid-instruction: the next edge returns to FETCH. No regwrite or memwrite is issued during or after the reset cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (4-bit);
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - alucontrol constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
  - aluop and alusrcb/pcsrc select codes.
- One sub-module, aludec (aluop[1:0], funct[5:0] → alucontrol[2:0]). The FSM and output decode stay in mips_multicycle_ctrl.

Test Plan:
- Reset: hold reset=1 for 2 cycles with op=100011 → state_o=0, all outputs 0. After release, first cycle shows irwrite=1, pcen=1, alusrcb=01 (mem_ready=1).
- lw, op=100011, mem_ready=1 → state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in cycle 5; iord=1 in cycle 4.
- sw with mem_ready low 3 cycles in MEMWR → memwrite=1 for exactly 4 cycles, then FETCH. regwrite never asserted.
- beq, op=000100: zero=1 → pcen=1 in BEQEX with pcsrc=01, alucontrol=110. Repeat with zero=0 → pcen=0.
- R-type, op=000000: funct=101010 → alucontrol=111 in RTYPEEX, regdst=1/regwrite=1 next cycle. funct=000111 → illegal_op pulse in DECODE, back to FETCH, no regwrite.
- Stall and reset: FETCH with mem_ready=0 for 5 cycles → irwrite/pcen stay 0. Asserting reset during MEMRD → state 0 next edge, no MEMWB regwrite.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct fields, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop plus the R-type funct field onto the
// 3-bit alu control code.
module mips_multicycle_ctrl_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB:   o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = ALU_ADD;
                    FN_SUB:  o_alucontrol = ALU_SUB;
                    FN_AND:  o_alucontrol = ALU_AND;
                    FN_OR:   o_alucontrol = ALU_OR;
                    FN_SLT:  o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default:     o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of datapath controls from the
// current state, qualified by mem_ready (memory stalls) and zero (beq).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite, w_branch, w_memwrite, w_irwrite, w_regwrite;
    logic       w_iord, w_memtoreg, w_regdst, w_alusrca, w_illegal;
    logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
    logic [2:0] w_alucontrol;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_iord     = 1'b0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_alusrca  = 1'b0;
        w_illegal  = 1'b0;
        w_alusrcb  = SRCB_B;
        w_pcsrc    = PCSRC_ALU;
        w_aluop    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = SRCB_FOUR;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) w_next = S_RTYPEEX;
                        else                    w_illegal = 1'b1;
                    end
                    default:      w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                w_pcsrc   = PCSRC_ALUOUT;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JEX: begin
                w_pcsrc   = PCSRC_JUMP;
                w_pcwrite = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    mips_multicycle_ctrl_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (w_alucontrol)
    );

    // Reset masks every control so no write can leak out of a reset cycle.
    always_comb begin
        pcen       = ~reset & (w_pcwrite | (w_branch & zero));
        memwrite   = ~reset & w_memwrite;
        irwrite    = ~reset & w_irwrite;
        regwrite   = ~reset & w_regwrite;
        iord       = ~reset & w_iord;
        memtoreg   = ~reset & w_memtoreg;
        regdst     = ~reset & w_regdst;
        alusrca    = ~reset & w_alusrca;
        illegal_op = ~reset & w_illegal;
        alusrcb    = reset ? 2'b00 : w_alusrcb;
        pcsrc      = reset ? 2'b00 : w_pcsrc;
        alucontrol = reset ? 3'b000 : w_alucontrol;
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle control unit: each step queues the full
// expected control vector, then pops and checks it mid-cycle.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b000000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    typedef struct packed {
        logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic [3:0] state;
    } outv_t;

    outv_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Argument order: state, pcen, memwrite, irwrite, regwrite, iord, memtoreg,
    // regdst, alusrca, alusrcb, pcsrc, alucontrol, illegal_op.
    function automatic outv_t ev(input logic [3:0] st, input logic pc, input logic mw,
                                 input logic irw, input logic rw, input logic io,
                                 input logic m2r, input logic rd, input logic sa,
                                 input logic [1:0] sb, input logic [1:0] ps,
                                 input logic [2:0] ac, input logic il);
        outv_t v;
        v.pcen = pc; v.memwrite = mw; v.irwrite = irw; v.regwrite = rw;
        v.iord = io; v.memtoreg = m2r; v.regdst = rd; v.alusrca = sa;
        v.alusrcb = sb; v.pcsrc = ps; v.alucontrol = ac; v.illegal_op = il;
        v.state = st;
        return v;
    endfunction

    task automatic step(input string tag, input outv_t e);
        outv_t o;
        outv_t x;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        o = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, alucontrol, illegal_op, state_o};
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (o === x) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, o, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step(tag, ev(4'd0, 1,0,1,0, 0,0,0,0, 2'b01, 2'b00, 3'b010, 0));
    endtask

    task automatic decode(input string tag, input logic ill);
        step(tag, ev(4'd1, 0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 3'b010, ill));
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("rst0", ev(4'd0, 0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        step("rst1", ev(4'd0, 0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        reset = 1'b0;

        // lw, no stalls
        fetch("lw_fetch");
        decode("lw_decode", 0);
        step("lw_memadr", ev(4'd2, 0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
        step("lw_memrd",  ev(4'd3, 0,0,0,0, 1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
        step("lw_memwb",  ev(4'd4, 0,0,0,1, 0,1,0,0, 2'b00, 2'b00, 3'b010, 0));

        // sw with three stall cycles in MEMWR
        op = 6'b101011;
        fetch("sw_fetch");
        decode("sw_decode", 0);
        step("sw_memadr", ev(4'd2, 0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("sw_memwr_stall", ev(4'd5, 0,1,0,0, 1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
        mem_ready = 1'b1;
        step("sw_memwr_done", ev(4'd5, 0,1,0,0, 1,0,0,0, 2'b00, 2'b00, 3'b010, 0));

        // beq taken then not taken
        op = 6'b000100;
        zero = 1'b1;
        fetch("beq1_fetch");
        decode("beq1_decode", 0);
        step("beq_taken", ev(4'd8, 1,0,0,0, 0,0,0,1, 2'b00, 2'b01, 3'b110, 0));
        zero = 1'b0;
        fetch("beq0_fetch");
        decode("beq0_decode", 0);
        step("beq_not_taken", ev(4'd8, 0,0,0,0, 0,0,0,1, 2'b00, 2'b01, 3'b110, 0));

        // R-type slt
        op = 6'b000000;
        funct = 6'b101010;
        fetch("slt_fetch");
        decode("slt_decode", 0);
        step("slt_ex", ev(4'd6, 0,0,0,0, 0,0,0,1, 2'b00, 2'b00, 3'b111, 0));
        step("slt_wb", ev(4'd7, 0,0,0,1, 0,0,1,0, 2'b00, 2'b00, 3'b010, 0));

        // R-type and
        funct = 6'b100100;
        fetch("and_fetch");
        decode("and_decode", 0);
        step("and_ex", ev(4'd6, 0,0,0,0, 0,0,0,1, 2'b00, 2'b00, 3'b000, 0));
        step("and_wb", ev(4'd7, 0,0,0,1, 0,0,1,0, 2'b00, 2'b00, 3'b010, 0));

        // R-type with unsupported funct
        funct = 6'b000111;
        fetch("badfn_fetch");
        decode("badfn_decode", 1);
        fetch("badfn_back_fetch");

        // addi (reuses the fetch above)
        op = 6'b001000;
        funct = 6'b000000;
        decode("addi_decode", 0);
        step("addi_ex", ev(4'd9,  0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
        step("addi_wb", ev(4'd10, 0,0,0,1, 0,0,0,0, 2'b00, 2'b00, 3'b010, 0));

        // j
        op = 6'b000010;
        fetch("j_fetch");
        decode("j_decode", 0);
        step("j_ex", ev(4'd11, 1,0,0,0, 0,0,0,0, 2'b00, 2'b10, 3'b010, 0));

        // unsupported opcode
        op = 6'b111111;
        fetch("badop_fetch");
        decode("badop_decode", 1);

        // fetch stall for five cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step("fetch_stall", ev(4'd0, 0,0,0,0, 0,0,0,0, 2'b01, 2'b00, 3'b010, 0));
        mem_ready = 1'b1;
        op = 6'b100011;
        fetch("stall_release_fetch");

        // lw interrupted by reset while waiting in MEMRD
        decode("lwr_decode", 0);
        step("lwr_memadr", ev(4'd2, 0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 3'b010, 0));
        mem_ready = 1'b0;
        step("lwr_memrd", ev(4'd3, 0,0,0,0, 1,0,0,0, 2'b00, 2'b00, 3'b010, 0));
        reset = 1'b1;
        mem_ready = 1'b1;
        step("lwr_reset_cycle", ev(4'd3, 0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        reset = 1'b0;
        fetch("lwr_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
